// File: rtl/sys_array_pkg.sv
// Shared types and sizing helpers for the systolic-array feeder.
package sys_array_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_W = 3'd1,
        FEED   = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } state_t;

    // Feed steps needed to push every element through the diagonal skew.
    function automatic int calc_nf(input int a_w, input int a_l);
        return a_l + a_w - 1;
    endfunction

    // One counter is shared by FEED and DRAIN, so it must cover the longer of the two.
    function automatic int calc_cnt_w(input int nf, input int drain);
        int m;
        m = (nf > drain) ? nf : drain;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sys_array_skew_lane.sv
// One feed lane: picks element (step - LANE) of its row when inside the window, else zero.
module sys_array_skew_lane #(
    parameter int DATA_WIDTH = 8,
    parameter int ARRAY_A_L  = 4,
    parameter int CNT_W      = 4,
    parameter int LANE       = 0
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic                                  en,
    input  logic [CNT_W-1:0]                      step,
    input  logic [0:ARRAY_A_L-1][DATA_WIDTH-1:0]  row,
    output logic [DATA_WIDTH-1:0]                 lane_data
);

    int                    diff;
    logic [DATA_WIDTH-1:0] elem_d;

    // The column loop doubles as the upper bound of the skew window.
    always_comb begin
        diff   = int'(step) - LANE;
        elem_d = '0;
        if (en && diff >= 0) begin
            for (int c = 0; c < ARRAY_A_L; c++) begin
                if (diff == c) elem_d = row[c];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) lane_data <= '0;
        else          lane_data <= elem_d;
    end

endmodule

// File: rtl/sys_array_feeder.sv
// Captures operands on a start handshake, strobes the weight load, then feeds skewed lanes and drains.
module sys_array_feeder
    import sys_array_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int ARRAY_W_W    = 4,
    parameter int ARRAY_W_L    = 4,
    parameter int ARRAY_A_W    = 4,
    parameter int ARRAY_A_L    = 4,
    parameter int DRAIN_CYCLES = 8
) (
    input  logic                                                   clk,
    input  logic                                                   reset_n,
    input  logic                                                   start,
    output logic                                                   start_ready,
    input  logic [0:ARRAY_A_W-1][0:ARRAY_A_L-1][DATA_WIDTH-1:0]    data_matrix,
    input  logic [0:ARRAY_W_W-1][0:ARRAY_W_L-1][DATA_WIDTH-1:0]    weight_matrix,
    output logic                                                   weights_load,
    output logic [0:ARRAY_W_W-1][0:ARRAY_W_L-1][DATA_WIDTH-1:0]    weight_data,
    output logic [0:ARRAY_A_W-1][DATA_WIDTH-1:0]                   input_data,
    output logic                                                   feed_valid,
    output logic                                                   busy,
    output logic                                                   done
);

    localparam int NF = calc_nf(ARRAY_A_W, ARRAY_A_L);
    localparam int CW = calc_cnt_w(NF, DRAIN_CYCLES);
    localparam logic [CW-1:0] FEED_LAST  = CW'(NF - 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYCLES - 1);

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          xfer;
    logic          ready_d, load_d, feed_d, done_d;

    logic [0:ARRAY_A_W-1][0:ARRAY_A_L-1][DATA_WIDTH-1:0] data_q;

    assign xfer = start & start_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE:   if (xfer) state_nx = LOAD_W;
            LOAD_W: begin
                state_nx = FEED;
                cnt_nx   = '0;
            end
            FEED: begin
                if (cnt == FEED_LAST) begin
                    state_nx = DRAIN;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            DRAIN: begin
                if (cnt == DRAIN_LAST) begin
                    state_nx = DONE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs are decoded from the upcoming state so each registered flag lines up with its state.
    always_comb begin
        ready_d = (state_nx == IDLE);
        load_d  = (state_nx == LOAD_W);
        feed_d  = (state_nx == FEED);
        done_d  = (state_nx == DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            start_ready  <= 1'b1;
            busy         <= 1'b0;
            weights_load <= 1'b0;
            feed_valid   <= 1'b0;
            done         <= 1'b0;
        end else begin
            start_ready  <= ready_d;
            busy         <= ~ready_d;
            weights_load <= load_d;
            feed_valid   <= feed_d;
            done         <= done_d;
        end
    end

    // weight_data is the captured weight copy itself; it persists until the next transfer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q      <= '0;
            weight_data <= '0;
        end else if (xfer) begin
            data_q      <= data_matrix;
            weight_data <= weight_matrix;
        end
    end

    for (genvar k = 0; k < ARRAY_A_W; k++) begin : g_lane
        sys_array_skew_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .ARRAY_A_L  (ARRAY_A_L),
            .CNT_W      (CW),
            .LANE       (k)
        ) u_lane (
            .clk       (clk),
            .reset_n   (reset_n),
            .en        (feed_d),
            .step      (cnt_nx),
            .row       (data_q[k]),
            .lane_data (input_data[k])
        );
    end

endmodule

// File: doc/sys_array_feeder.md
Name: sys_array_feeder

Overview:
Control and skew stage directly upstream of the systolic array core. It captures one data matrix and one weight matrix on a start handshake. It then pulses the core's weight-load and streams the data matrix into the core's input lanes with diagonal skew: lane k is delayed k cycles. After the last element it drains the pipeline with zeros and signals completion.

Parameters:
DATA_WIDTH, 8, element width in bits
ARRAY_W_W, 4, weight rows (core rows)
ARRAY_W_L, 4, weight columns (core columns)
ARRAY_A_W, 4, data-matrix rows = number of feed lanes
ARRAY_A_L, 4, data-matrix columns = elements per lane
DRAIN_CYCLES, 8, zero-input cycles after the last feed step (must be >= 1)

Ports:
clk  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  request: capture matrices and run one pass
start_ready  out  1  high while IDLE; a transfer occurs on start & start_ready
data_matrix  in  [0:ARRAY_A_W-1][0:ARRAY_A_L-1][DATA_WIDTH-1:0]  data operand, sampled on the transfer
weight_matrix  in  [0:ARRAY_W_W-1][0:ARRAY_W_L-1][DATA_WIDTH-1:0]  weights, sampled on the transfer
weights_load  out  1  one-cycle load strobe to the core
weight_data  out  [0:ARRAY_W_W-1][0:ARRAY_W_L-1][DATA_WIDTH-1:0]  registered weights to the core
input_data  out  [0:ARRAY_A_W-1][DATA_WIDTH-1:0]  skewed lane data to the core
feed_valid  out  1  high during FEED cycles
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse at the end of the pass

Behaviour:
- Reset (async assert, sync release) forces the following; all outputs are registered:
  - state IDLE, start_ready=1;
  - busy=0, done=0, weights_load=0, feed_valid=0;
  - input_data all zero, weight_data all zero;
  - captured matrices and counters cleared.
- FSM states: IDLE -> LOAD_W -> FEED -> DRAIN -> DONE -> IDLE.
- IDLE:
  - start_ready=1.
  - On start=1, capture data_matrix and weight_matrix into internal registers, then go to LOAD_W.
- LOAD_W (exactly 1 cycle):
  - weights_load=1; weight_data shows the captured weights.
  - Step counter t cleared.
- FEED: lasts NF = ARRAY_A_L + ARRAY_A_W - 1 cycles, with t = 0..NF-1.
  - feed_valid=1.
  - Lane k outputs data[k][t-k] when 0 <= t-k < ARRAY_A_L, else 0.
  - At t = NF-1, go to DRAIN.
- DRAIN: lasts DRAIN_CYCLES cycles; input_data=0, feed_valid=0.
- DONE (1 cycle): done=1, then return to IDLE.
- weight_data holds the captured weights from LOAD_W until the next transfer; it is not cleared at DONE.
- start while busy is ignored. No queueing; the external driver must wait for start_ready.
- Latency, counted from the transfer edge (cycle 0):
  - weights_load high in cycle 1;
  - first feed in cycle 2;
  - done in cycle 2 + NF + DRAIN_CYCLES.
- Degenerate sizes:
  - ARRAY_A_W=1 gives no skew (NF = ARRAY_A_L).
  - ARRAY_A_L=1 makes each lane carry a single element.
- Counter widths are sized with $clog2 of max(NF, DRAIN_CYCLES) + 1. Counters never wrap within a pass.
- Asserting reset_n low mid-pass aborts the pass immediately: every output returns to its reset value and no done is produced.
- Input matrices may change freely after the transfer; only the captured copy is used.

Decomposition:
- Package sys_array_pkg holds:
  - the state enum typedef (IDLE, LOAD_W, FEED, DRAIN, DONE);
  - localparam functions for NF and the counter width.
- One sub-module, sys_array_skew_lane, is instantiated once per lane k:
  - inputs: the lane's captured row, step t, lane index k as a parameter;
  - output: the registered lane element;
  - it owns the skew window check.

Test Plan:
1. Reset with defaults (4x4) -> start_ready=1, all outputs 0; drop reset_n mid-FEED -> outputs return to 0 at once and done never pulses.
2. 4x4 start with data[k][c]=10*k+c+1 -> weights_load only in cycle 1. Lane values across cycles 2..8:
   - lane0: 1,2,3,4,0,0,0
   - lane1: 0,11,12,13,14,0,0
   - lane3: 0,0,0,31,32,33,34
3. Same pass -> feed_valid high for exactly 7 cycles; zeros for 8 drain cycles; done pulses in cycle 17; start_ready returns in cycle 18.
4. start held high through a whole pass with data changed in cycle 3 -> second pass starts only after IDLE and uses the data present at that new transfer; the change in cycle 3 does not affect the first pass.
5. weight_matrix[i][j]=i*4+j, changed after the transfer -> weight_data holds the captured values at weights_load and for the whole pass.
6. ARRAY_A_W=2, ARRAY_A_L=3, DRAIN_CYCLES=1 -> NF=4, done in cycle 7.
